branch_recovery: RTL and testbench
==================================

# branch_recovery

Backend recovery controller that consumes the `b_data` result stream from `fu_branch` and turns a flagged mispredict into a flush, a ROB rollback walk and a fetch redirect. On a mispredict it latches the branch's ROB tag and target. It broadcasts a one-cycle `mispredict`/`mispredict_tag` kill to the FUs and RS. It then walks the ROB from tail-1 back to tag+1, restoring the rename map and returning physical registers to the free list. Finally it redirects fetch and sets the ROB tail to tag+1. It sits between `fu_branch`, the ROB, the RAT/free list and fetch.

## Interface
- `ROB_DEPTH`, 32: ROB entries, power of two; `ROB_W = $clog2(ROB_DEPTH)`.
- `PREG_W`, 7: physical register index width.
- `clk`  in  1: clock.
- `reset`  in  1: asynchronous, active-high reset.
- `b_in`  in  `b_data`: branch result from `fu_branch`. Uses `fu_b_done`, `mispredict`, `mispredict_tag` and `pc` (target).
- `rob_head`  in  ROB_W: oldest ROB entry, used for age comparison.
- `rob_tail`  in  ROB_W: next free ROB slot (`curr_rob_tag`).
- `walk_idx`  out  ROB_W: ROB index read this cycle; the ROB read is combinational.
- `walk_has_dest`, `walk_rd[4:0]`, `walk_pd_new[PREG_W-1:0]`, `walk_pd_old[PREG_W-1:0]`  in: fields of ROB entry `walk_idx`.
- `mispredict`  out  1: kill pulse to FUs/RS.
- `mispredict_tag`  out  ROB_W: tag of the mispredicting branch.
- `rat_wr_en`, `rat_wr_arch[4:0]`, `rat_wr_preg[PREG_W-1:0]`  out: map-table restore.
- `free_valid`, `free_preg[PREG_W-1:0]`  out: free-list return.
- `rob_tail_wr`, `rob_tail_new[ROB_W-1:0]`  out: ROB tail restore.
- `redirect_valid`, `redirect_pc[31:0]`  out: fetch redirect.
- `stall_frontend`  out  1: blocks rename and dispatch.

## Operation
- Trigger: `b_in.fu_b_done && b_in.mispredict`. On trigger, latch `tag`, `target = b_in.pc` and `tail = rob_tail`.
- FSM states: IDLE, FLUSH, WALK, REDIRECT.
- IDLE → FLUSH on trigger. The walk pointer is set to `tail-1` mod ROB_DEPTH.
- FLUSH (1 cycle): `mispredict=1`, `mispredict_tag=tag`.
  - If walk pointer == tag (no younger entries), go to REDIRECT.
  - Otherwise go to WALK.
- WALK (1 entry/cycle): `walk_idx` = walk pointer.
  - If `walk_has_dest`: assert `rat_wr_en` with arch `walk_rd` and preg `walk_pd_old`. In the same cycle assert `free_valid` with `free_preg = walk_pd_new`.
  - If the pointer == tag+1, go to REDIRECT. Otherwise decrement the pointer mod ROB_DEPTH.
- REDIRECT (1 cycle): assert `redirect_valid` with `redirect_pc = target`, and `rob_tail_wr` with `rob_tail_new = tag+1`. Then go to IDLE.
- `stall_frontend = (state != IDLE)`.
- Age rule: `age(x) = (x - rob_head) mod ROB_DEPTH`; a smaller age is older.
- Trigger while not IDLE:
  - Accepted only if `age(new tag) < age(latched tag)`.
  - If accepted, relatch `tag` and `target` and enter FLUSH. The walk pointer is kept, because entries already undone stay undone.
  - If the current WALK cycle is processing an entry, that entry's restore still completes. The walk then continues down to newtag+1.
  - A younger or equal-age trigger is ignored; `fu_branch` kills it anyway.
- All ROB index arithmetic is ROB_W bits and wraps naturally.
- `walk_idx` outside WALK drives the walk pointer; it is don't-care to the ROB.

## Timing
- Reset (asynchronous): state IDLE and all outputs 0, including `walk_idx`, `redirect_pc` and `mispredict_tag`. Reset mid-walk aborts to IDLE with no further restores.
- The state registers a trigger at the posedge. `mispredict` is high in the cycle after the `b_in` trigger cycle.
- Latency from trigger to `redirect_valid` is 2 + N cycles, where N = number of younger entries, `(tail-1-tag) mod ROB_DEPTH`. N=0 gives 2 cycles.
- `rat_wr_en`/`free_valid` are combinational from state and ROB read data, and are valid only in WALK.
- `mispredict`, `redirect_valid` and `rob_tail_wr` are single-cycle pulses.

## Structure
- `types_pkg` gains:
  - `recov_state_t` enum (IDLE/FLUSH/WALK/REDIRECT).
  - An `rob_walk_t` struct (`has_dest`, `rd`, `pd_new`, `pd_old`).
  - `ROB_W` and `PREG_W` constants.
- `b_data` is reused unchanged.
- One sub-module, `rob_age_cmp`: combinational `age(a) < age(b)` relative to head.

## Test plan
- Reset asserted mid-idle → all outputs 0 and `stall_frontend=0`.
- Trigger with tag 12, pc 2100, tail 13 → `mispredict=1`/tag 12 next cycle, then `redirect_valid` with pc 2100, `rob_tail_new=13`, and no RAT/free writes.
- Trigger with tag 1, tail 5, entries 4/3/2 having dest (rd 3/4/5, pd_new 40/41/42, pd_old 10/11/12) → WALK visits idx 4,3,2. It frees 40,41,42 and restores rd3←10, rd4←11, rd5←12, then `rob_tail_new=2`.
- Wrap: tag 30, tail 2 → walk idx 1,0,31, then `rob_tail_new=31`.
- Setup: head 0, walk of tag 10 in progress at pointer 20. An older trigger (tag 5, pc 0x400) re-pulses `mispredict` with tag 5, the walk continues 19..6, and redirect goes to 0x400 with tail 6. A younger trigger (tag 15) in the same setup is ignored.
- Reset asserted during WALK → immediate IDLE, no `redirect_valid`.

Source files
------------

// File: rtl/types_pkg.sv
// Shared backend types: branch result bus, recovery FSM states and ROB walk entry.
package types_pkg;

    localparam int unsigned ROB_W  = 5;
    localparam int unsigned PREG_W = 7;

    typedef struct packed {
        logic              fu_b_done;
        logic              mispredict;
        logic [ROB_W-1:0]  mispredict_tag;
        logic [31:0]       pc;
    } b_data;

    typedef enum logic [1:0] {
        IDLE,
        FLUSH,
        WALK,
        REDIRECT
    } recov_state_t;

    typedef struct packed {
        logic              has_dest;
        logic [4:0]        rd;
        logic [PREG_W-1:0] pd_new;
        logic [PREG_W-1:0] pd_old;
    } rob_walk_t;

endpackage

// File: rtl/rob_age_cmp.sv
// Combinational ROB age compare: older = age(a) < age(b), ages measured from head.
module rob_age_cmp #(
    parameter int unsigned ROB_W = 5
) (
    input  logic [ROB_W-1:0] a,
    input  logic [ROB_W-1:0] b,
    input  logic [ROB_W-1:0] head,
    output logic             older
);

    logic [ROB_W-1:0] age_a;
    logic [ROB_W-1:0] age_b;

    always_comb begin
        age_a = a - head;
        age_b = b - head;
        older = (age_a < age_b);
    end

endmodule

// File: rtl/branch_recovery.sv
// Mispredict recovery: kill pulse, ROB rollback walk (RAT restore + free list
// return), then fetch redirect and ROB tail restore.
module branch_recovery #(
    parameter int unsigned ROB_DEPTH = 32,
    parameter int unsigned PREG_W    = 7,
    localparam int unsigned ROB_W    = $clog2(ROB_DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  types_pkg::b_data     b_in,
    input  logic [ROB_W-1:0]     rob_head,
    input  logic [ROB_W-1:0]     rob_tail,
    output logic [ROB_W-1:0]     walk_idx,
    input  logic                 walk_has_dest,
    input  logic [4:0]           walk_rd,
    input  logic [PREG_W-1:0]    walk_pd_new,
    input  logic [PREG_W-1:0]    walk_pd_old,
    output logic                 mispredict,
    output logic [ROB_W-1:0]     mispredict_tag,
    output logic                 rat_wr_en,
    output logic [4:0]           rat_wr_arch,
    output logic [PREG_W-1:0]    rat_wr_preg,
    output logic                 free_valid,
    output logic [PREG_W-1:0]    free_preg,
    output logic                 rob_tail_wr,
    output logic [ROB_W-1:0]     rob_tail_new,
    output logic                 redirect_valid,
    output logic [31:0]          redirect_pc,
    output logic                 stall_frontend
);

    import types_pkg::*;

    localparam logic [ROB_W-1:0] IDX_ONE = ROB_W'(1);

    recov_state_t     state, state_nx;
    logic [ROB_W-1:0] ptr, ptr_nx;
    logic [ROB_W-1:0] tag, tag_nx;
    logic [31:0]      target, target_nx;
    logic [ROB_W-1:0] tag_p1;
    logic             trigger;
    logic             new_older;
    rob_walk_t        walk;

    always_comb begin
        trigger = b_in.fu_b_done && b_in.mispredict;
        tag_p1  = tag + IDX_ONE;
        walk    = '{has_dest: walk_has_dest, rd: walk_rd,
                    pd_new: walk_pd_new, pd_old: walk_pd_old};
    end

    rob_age_cmp #(
        .ROB_W (ROB_W)
    ) u_age_cmp (
        .a     (b_in.mispredict_tag),
        .b     (tag),
        .head  (rob_head),
        .older (new_older)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            ptr    <= '0;
            tag    <= '0;
            target <= '0;
        end else begin
            state  <= state_nx;
            ptr    <= ptr_nx;
            tag    <= tag_nx;
            target <= target_nx;
        end
    end

    always_comb begin
        state_nx       = state;
        ptr_nx         = ptr;
        tag_nx         = tag;
        target_nx      = target;
        mispredict     = 1'b0;
        mispredict_tag = '0;
        rat_wr_en      = 1'b0;
        rat_wr_arch    = '0;
        rat_wr_preg    = '0;
        free_valid     = 1'b0;
        free_preg      = '0;
        rob_tail_wr    = 1'b0;
        rob_tail_new   = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        unique case (state)
            IDLE: begin
                if (trigger) begin
                    state_nx  = FLUSH;
                    tag_nx    = b_in.mispredict_tag;
                    target_nx = b_in.pc;
                    ptr_nx    = rob_tail - IDX_ONE;
                end
            end
            FLUSH: begin
                mispredict     = 1'b1;
                mispredict_tag = tag;
                state_nx       = (ptr == tag) ? REDIRECT : WALK;
            end
            WALK: begin
                if (walk.has_dest) begin
                    rat_wr_en   = 1'b1;
                    rat_wr_arch = walk.rd;
                    rat_wr_preg = walk.pd_old;
                    free_valid  = 1'b1;
                    free_preg   = walk.pd_new;
                end
                // Always step past the undone entry so that after the walk the
                // pointer rests on the branch itself; a later older trigger
                // then resumes from exactly the first not-yet-undone entry.
                ptr_nx = ptr - IDX_ONE;
                if (ptr == tag_p1) begin
                    state_nx = REDIRECT;
                end
            end
            REDIRECT: begin
                redirect_valid = 1'b1;
                redirect_pc    = target;
                rob_tail_wr    = 1'b1;
                rob_tail_new   = tag_p1;
                state_nx       = IDLE;
            end
            default: state_nx = IDLE;
        endcase

        // Older branch while busy: re-flush with the new tag, keep the walk pointer.
        if (state != IDLE && trigger && new_older) begin
            state_nx  = FLUSH;
            tag_nx    = b_in.mispredict_tag;
            target_nx = b_in.pc;
        end
    end

    always_comb begin
        walk_idx       = ptr;
        stall_frontend = (state != IDLE);
    end

endmodule

// File: tb/tb_branch_recovery.sv
// Directed bench for branch_recovery: per-cycle expectation queue built from
// the recovery rules, plus literal checks on logged walk/redirect activity.
module tb_branch_recovery;
    import types_pkg::*;

    localparam int unsigned RW = 5;
    localparam int unsigned PW = 7;

    logic          clk = 1'b0;
    logic          reset;
    b_data         b_in;
    logic [RW-1:0] rob_head, rob_tail, walk_idx, mispredict_tag, rob_tail_new;
    logic          walk_has_dest;
    logic [4:0]    walk_rd;
    logic [PW-1:0] walk_pd_new, walk_pd_old;
    logic          mispredict, rat_wr_en, free_valid, rob_tail_wr;
    logic          redirect_valid, stall_frontend;
    logic [4:0]    rat_wr_arch;
    logic [PW-1:0] rat_wr_preg, free_preg;
    logic [31:0]   redirect_pc;

    always #5 clk = ~clk;

    branch_recovery #(.ROB_DEPTH(32), .PREG_W(7)) dut (
        .clk            (clk),
        .reset          (reset),
        .b_in           (b_in),
        .rob_head       (rob_head),
        .rob_tail       (rob_tail),
        .walk_idx       (walk_idx),
        .walk_has_dest  (walk_has_dest),
        .walk_rd        (walk_rd),
        .walk_pd_new    (walk_pd_new),
        .walk_pd_old    (walk_pd_old),
        .mispredict     (mispredict),
        .mispredict_tag (mispredict_tag),
        .rat_wr_en      (rat_wr_en),
        .rat_wr_arch    (rat_wr_arch),
        .rat_wr_preg    (rat_wr_preg),
        .free_valid     (free_valid),
        .free_preg      (free_preg),
        .rob_tail_wr    (rob_tail_wr),
        .rob_tail_new   (rob_tail_new),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall_frontend (stall_frontend)
    );

    // ROB contents, read combinationally at walk_idx
    logic          rob_has [32];
    logic [4:0]    rob_rd  [32];
    logic [PW-1:0] rob_new [32];
    logic [PW-1:0] rob_old [32];

    assign walk_has_dest = rob_has[walk_idx];
    assign walk_rd       = rob_rd[walk_idx];
    assign walk_pd_new   = rob_new[walk_idx];
    assign walk_pd_old   = rob_old[walk_idx];

    typedef struct {
        logic          stall;
        logic          mp;
        logic [RW-1:0] mp_tag;
        logic          walk;
        logic [RW-1:0] idx;
        logic          rat;
        logic [4:0]    arch;
        logic [PW-1:0] rpreg;
        logic          fr;
        logic [PW-1:0] fpreg;
        logic          red;
        logic [31:0]   pc;
        logic [RW-1:0] tnew;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    logic run    = 1'b1;

    // Activity logs
    logic [31:0] free_log [64];
    logic [31:0] rat_log  [64];
    logic [31:0] idx_log  [64];
    logic [31:0] mp_log   [8];
    logic [31:0] rpc_log  [8];
    logic [31:0] tnew_log [8];
    int n_free, n_rat, n_mp, n_red;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_logs();
        n_free = 0; n_rat = 0; n_mp = 0; n_red = 0;
        for (int i = 0; i < 64; i++) begin
            free_log[i] = '0; rat_log[i] = '0; idx_log[i] = '0;
        end
        for (int i = 0; i < 8; i++) begin
            mp_log[i] = '0; rpc_log[i] = '0; tnew_log[i] = '0;
        end
    endtask

    task automatic clear_rob();
        for (int i = 0; i < 32; i++) begin
            rob_has[i] = 1'b0; rob_rd[i] = '0; rob_new[i] = '0; rob_old[i] = '0;
        end
    endtask

    task automatic fill_rob();
        for (int i = 0; i < 32; i++) begin
            rob_has[i] = 1'b1;
            rob_rd[i]  = 5'(i);
            rob_new[i] = PW'(64 + i);
            rob_old[i] = PW'(i);
        end
    endtask

    // ---------------- model: expected per-cycle outputs ----------------
    task automatic push_idle();
        exp_t e = '{default: '0};
        exp_q.push_back(e);
    endtask

    task automatic push_flush(input int tag);
        exp_t e = '{default: '0};
        e.stall = 1'b1; e.mp = 1'b1; e.mp_tag = RW'(tag);
        exp_q.push_back(e);
    endtask

    task automatic push_walks(input int from, input int n);
        for (int k = 0; k < n; k++) begin
            exp_t e = '{default: '0};
            int idx = (from - k + 64) % 32;
            e.stall = 1'b1; e.walk = 1'b1; e.idx = RW'(idx);
            e.rat = rob_has[idx]; e.arch = rob_rd[idx]; e.rpreg = rob_old[idx];
            e.fr  = rob_has[idx]; e.fpreg = rob_new[idx];
            exp_q.push_back(e);
        end
    endtask

    task automatic push_redirect(input logic [31:0] pc, input int tag);
        exp_t e = '{default: '0};
        e.stall = 1'b1; e.red = 1'b1; e.pc = pc; e.tnew = RW'((tag + 1) % 32);
        exp_q.push_back(e);
    endtask

    // One complete recovery: flush, every younger entry newest first, redirect.
    task automatic model_recovery(input int tag, input int tail, input logic [31:0] pc);
        int n = (tail - 1 - tag + 64) % 32;
        push_flush(tag);
        push_walks((tail - 1 + 32) % 32, n);
        push_redirect(pc, tag);
    endtask

    // ---------------- compare + monitor ----------------
    always @(negedge clk) begin : cmp
        exp_t        e;
        logic [71:0] exp_v, act_v;
        if (run) begin
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else                  e = '{default: '0};
            exp_v = {e.stall, e.mp, e.mp_tag & {RW{e.mp}}, e.idx & {RW{e.walk}},
                     e.rat, e.arch & {5{e.rat}}, e.rpreg & {PW{e.rat}},
                     e.fr, e.fpreg & {PW{e.fr}},
                     e.red, e.pc & {32{e.red}}, e.red, e.tnew & {RW{e.red}}};
            act_v = {stall_frontend, mispredict, mispredict_tag & {RW{e.mp}},
                     walk_idx & {RW{e.walk}},
                     rat_wr_en, rat_wr_arch & {5{e.rat}}, rat_wr_preg & {PW{e.rat}},
                     free_valid, free_preg & {PW{e.fr}},
                     redirect_valid, redirect_pc & {32{e.red}},
                     rob_tail_wr, rob_tail_new & {RW{e.red}}};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL cycle_outputs t=%0t got %h expected %h", $time, act_v, exp_v);
            end
        end
    end

    always @(negedge clk) begin : mon
        if (free_valid) begin
            if (n_free < 64) begin
                free_log[n_free] = 32'(free_preg);
                idx_log[n_free]  = 32'(walk_idx);
            end
            n_free++;
        end
        if (rat_wr_en) begin
            if (n_rat < 64) rat_log[n_rat] = 32'({rat_wr_arch, rat_wr_preg});
            n_rat++;
        end
        if (mispredict) begin
            if (n_mp < 8) mp_log[n_mp] = 32'(mispredict_tag);
            n_mp++;
        end
        if (redirect_valid) begin
            if (n_red < 8) begin
                rpc_log[n_red]  = redirect_pc;
                tnew_log[n_red] = 32'(rob_tail_new);
            end
            n_red++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input int tag, input logic [31:0] pc);
        b_in.fu_b_done      = 1'b1;
        b_in.mispredict     = 1'b1;
        b_in.mispredict_tag = RW'(tag);
        b_in.pc             = pc;
    endtask

    // Caller is just after a posedge with expectations already queued.
    // Optional second trigger is presented during cycle t2_at after the first.
    task automatic run_trig(input int tag, input int tail, input logic [31:0] pc,
                            input int t2_at, input int t2_tag, input logic [31:0] t2_pc,
                            output int lat);
        lat = -1;
        rob_tail = RW'(tail);
        drive(tag, pc);
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (k == 1 || (t2_at > 0 && k == t2_at + 1)) b_in = '0;
            if (t2_at > 0 && k == t2_at) drive(t2_tag, t2_pc);
            if (redirect_valid && lat < 0) lat = k;
            if (lat >= 0 && k >= lat + 2) break;
        end
        b_in = '0;
        if (lat < 0) begin
            checks++; errors++;
            $display("FAIL redirect_timeout: got none expected redirect_valid within 80 cycles");
            exp_q.delete();
        end
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_ctrl"},
              64'({walk_idx, mispredict, mispredict_tag, rat_wr_en, rat_wr_arch, rat_wr_preg,
                   free_valid, free_preg, rob_tail_wr, rob_tail_new, redirect_valid,
                   stall_frontend}), 64'd0);
        check({name, "_pc"}, 64'(redirect_pc), 64'd0);
        check({name, "_stall"}, 64'(stall_frontend), 64'd0);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got no finish expected finish before 100000 time units");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int lat;
        reset = 1'b1; b_in = '0; rob_head = '0; rob_tail = '0;
        clear_rob(); clear_logs();
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset_initial");
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset while idle
        reset = 1'b1;
        #2;
        check_idle_outputs("reset_idle");
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // No younger entries: tag 12, tail 13
        clear_logs(); clear_rob(); rob_head = 5'd12;
        push_idle(); model_recovery(12, 13, 32'd2100);
        run_trig(12, 13, 32'd2100, 0, 0, '0, lat);
        check("t2_latency", 64'(lat), 64'd2);
        check("t2_mp_tag", 64'(mp_log[0]), 64'd12);
        check("t2_redirect_pc", 64'(rpc_log[0]), 64'd2100);
        check("t2_tail_new", 64'(tail_new_of(0)), 64'd13);
        check("t2_no_writes", 64'(n_rat + n_free), 64'd0);

        // Three younger entries with destinations
        @(posedge clk); #1;
        clear_logs(); clear_rob(); rob_head = 5'd0;
        rob_has[4] = 1'b1; rob_rd[4] = 5'd3; rob_new[4] = 7'd40; rob_old[4] = 7'd10;
        rob_has[3] = 1'b1; rob_rd[3] = 5'd4; rob_new[3] = 7'd41; rob_old[3] = 7'd11;
        rob_has[2] = 1'b1; rob_rd[2] = 5'd5; rob_new[2] = 7'd42; rob_old[2] = 7'd12;
        push_idle(); model_recovery(1, 5, 32'h1000);
        run_trig(1, 5, 32'h1000, 0, 0, '0, lat);
        check("t3_latency", 64'(lat), 64'd5);
        check("t3_free0", 64'(free_log[0]), 64'd40);
        check("t3_free1", 64'(free_log[1]), 64'd41);
        check("t3_free2", 64'(free_log[2]), 64'd42);
        check("t3_rat0", 64'(rat_log[0]), 64'({5'd3, 7'd10}));
        check("t3_rat1", 64'(rat_log[1]), 64'({5'd4, 7'd11}));
        check("t3_rat2", 64'(rat_log[2]), 64'({5'd5, 7'd12}));
        check("t3_tail_new", 64'(tail_new_of(0)), 64'd2);

        // Wrap-around walk: tag 30, tail 2
        @(posedge clk); #1;
        clear_logs(); clear_rob(); rob_head = 5'd28;
        rob_has[1] = 1'b1; rob_has[0] = 1'b1; rob_has[31] = 1'b1;
        push_idle(); model_recovery(30, 2, 32'h2000);
        run_trig(30, 2, 32'h2000, 0, 0, '0, lat);
        check("wrap_idx0", 64'(idx_log[0]), 64'd1);
        check("wrap_idx1", 64'(idx_log[1]), 64'd0);
        check("wrap_idx2", 64'(idx_log[2]), 64'd31);
        check("wrap_tail_new", 64'(tail_new_of(0)), 64'd31);

        // Older trigger (tag 5) arrives while walking tag 10 at pointer 20
        @(posedge clk); #1;
        clear_logs(); fill_rob(); rob_head = 5'd0;
        push_idle(); push_flush(10); push_walks(24, 5);
        push_flush(5); push_walks(19, 14); push_redirect(32'h400, 5);
        run_trig(10, 25, 32'h3000, 6, 5, 32'h400, lat);
        check("old_latency", 64'(lat), 64'd22);
        check("old_mp_count", 64'(n_mp), 64'd2);
        check("old_mp_tag0", 64'(mp_log[0]), 64'd10);
        check("old_mp_tag1", 64'(mp_log[1]), 64'd5);
        check("old_walk_count", 64'(n_free), 64'd19);
        check("old_idx_at_retrigger", 64'(idx_log[4]), 64'd20);
        check("old_idx_resume", 64'(idx_log[5]), 64'd19);
        check("old_idx_last", 64'(idx_log[18]), 64'd6);
        check("old_redirect_pc", 64'(rpc_log[0]), 64'h400);
        check("old_tail_new", 64'(tail_new_of(0)), 64'd6);

        // Younger trigger (tag 15) in the same setup is ignored
        @(posedge clk); #1;
        clear_logs(); fill_rob(); rob_head = 5'd0;
        push_idle(); model_recovery(10, 25, 32'h3000);
        run_trig(10, 25, 32'h3000, 6, 15, 32'h500, lat);
        check("young_latency", 64'(lat), 64'd16);
        check("young_mp_count", 64'(n_mp), 64'd1);
        check("young_redirect_pc", 64'(rpc_log[0]), 64'h3000);
        check("young_tail_new", 64'(tail_new_of(0)), 64'd11);

        // Reset during WALK aborts with no redirect
        @(posedge clk); #1;
        clear_logs(); fill_rob(); rob_head = 5'd0;
        push_idle(); model_recovery(1, 10, 32'h4000);
        rob_tail = 5'd10;
        drive(1, 32'h4000);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 1) b_in = '0;
        end
        #2;
        reset = 1'b1;
        exp_q.delete();
        #1;
        check_idle_outputs("reset_walk");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("reset_walk_no_redirect", 64'(n_red), 64'd0);
        check("reset_walk_restores", 64'(n_free), 64'd3);

        run = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    function automatic logic [31:0] tail_new_of(input int i);
        return tnew_log[i];
    endfunction

endmodule
